led_pattern_seq: RTL and testbench

Synchronous LED pattern sequencer that sits directly downstream of the 50 MHz half-second divider. It consumes the divider's square-wave `TIME` output as a step strobe and drives the four board LEDs. It replaces the ripple-clocked LED toggle chain with a single-clock design that offers four selectable patterns. A debounced, active-low push button cycles through the patterns.

---
 rtl/led_pattern_seq_if.sv | 13 +
 rtl/led_pattern_seq.sv | 182 ++++++++++++++++++
 tb/tb_led_pattern_seq.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/led_pattern_seq_if.sv
// Bus for the LED pattern sequencer: divider strobe and push button in,
// LED drive and current pattern out. CLK and RST stay plain module ports.
interface led_pattern_seq_if;
    logic       TIME;   // divider square wave, one step per rising edge
    logic       KEY;    // raw push button, active-low
    logic [3:0] LED;    // LED drive, 1 = lit
    logic [1:0] MODE;   // current pattern

    // Producer of TIME/KEY (board or bench) and consumer of LED/MODE.
    modport master (output TIME, KEY, input LED, MODE);
    // The sequencer itself.
    modport slave  (input TIME, KEY, output LED, MODE);
endinterface

// File: rtl/led_pattern_seq.sv
// LED pattern sequencer: single-clock replacement for the ripple-clocked LED
// toggle chain. Each rising edge of the divider's TIME output advances the
// active pattern by one step; a debounced press of KEY (active-low) selects
// the next of four patterns and clears the LEDs.
//
// Optional feature macro: LED_DEBOUNCE_EN
//   defined   - KEY must hold a new level for DEBOUNCE_CYCLES cycles before
//               it is accepted.
//   undefined - the synchronized KEY is accepted every cycle; every bounce
//               edge counts as a press and DEBOUNCE_CYCLES/DB_W are unused.
module led_pattern_seq #(
    parameter int DEBOUNCE_CYCLES = 1000000,  // 20 ms at 50 MHz
    parameter int DB_W            = 20
) (
    input  logic              CLK,
    input  logic              RST,     // synchronous, active-high
    led_pattern_seq_if.slave  io_bus
);

    typedef enum logic [1:0] {
        M_COUNT_UP   = 2'd0,
        M_COUNT_DOWN = 2'd1,
        M_CHASE      = 2'd2,
        M_BOUNCE     = 2'd3
    } mode_t;

    // Reject parameter sets the debounce counter cannot represent.
    if (DEBOUNCE_CYCLES < 2 ||
        longint'(DEBOUNCE_CYCLES) > ((longint'(1) << DB_W) - 1)) begin : g_bad_param
        $error("led_pattern_seq: DEBOUNCE_CYCLES must be in 2..2**DB_W-1");
    end

    logic       r_t1, r_t2, r_t3;
    logic       w_step;
    logic       r_k1, r_k2;
    logic       r_kd;
    logic       w_kd_nxt;
    logic       w_press;
    mode_t      r_mode, w_mode_nxt;
    logic [3:0] r_led, w_led_nxt;
    logic       r_dir, w_dir_nxt;      // BOUNCE direction, 0 = left
    logic       w_one_hot;

    // TIME synchronizer plus delay flop for rising-edge detection.
    always_ff @(posedge CLK) begin
        // NOTE: every clocked register uses <= so all flops sample the
        // pre-edge values; a blocking = here would collapse the chain.
        if (RST) begin
            r_t1 <= 1'b0;
            r_t2 <= 1'b0;
            r_t3 <= 1'b0;
        end else begin
            r_t1 <= io_bus.TIME;
            r_t2 <= r_t1;
            r_t3 <= r_t2;
        end
    end

    // Flops reset to 0, so TIME already high at reset release yields one step.
    assign w_step = r_t2 & ~r_t3;

    // KEY synchronizer; idle (released) level is 1.
    always_ff @(posedge CLK) begin
        // NOTE: the key path resets to the released level so coming out of
        // reset can never look like a press.
        if (RST) begin
            r_k1 <= 1'b1;
            r_k2 <= 1'b1;
        end else begin
            r_k1 <= io_bus.KEY;
            r_k2 <= r_k1;
        end
    end

`ifdef LED_DEBOUNCE_EN
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic [DB_W-1:0] r_db_cnt;
    logic            w_db_done;

    // New level has been stable long enough on this edge.
    assign w_db_done = (r_k2 != r_kd) && (r_db_cnt == DB_LAST);

    // Count consecutive cycles the synchronized key disagrees with the
    // accepted level; any return to the accepted level restarts the count.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_db_cnt <= '0;
        end else if ((r_k2 == r_kd) || w_db_done) begin
            r_db_cnt <= '0;
        end else begin
            r_db_cnt <= r_db_cnt + 1'b1;
        end
    end

    assign w_kd_nxt = w_db_done ? r_k2 : r_kd;
`else
    assign w_kd_nxt = r_k2;
`endif

    // Accepted (debounced) key level.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_kd <= 1'b1;
        end else begin
            r_kd <= w_kd_nxt;
        end
    end

    // Press fires on the same edge that the accepted level falls 1 -> 0.
    assign w_press = r_kd & ~w_kd_nxt;

    assign w_one_hot = (r_led == 4'b0001) || (r_led == 4'b0010) ||
                       (r_led == 4'b0100) || (r_led == 4'b1000);

    // Pattern state register: mode, LED drive and bounce direction.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_mode <= M_COUNT_UP;
            r_led  <= 4'b0000;
            r_dir  <= 1'b0;
        end else begin
            r_mode <= w_mode_nxt;
            r_led  <= w_led_nxt;
            r_dir  <= w_dir_nxt;
        end
    end

    // Next state: a press beats a coincident step, which is then dropped.
    always_comb begin
        // NOTE: hold values are assigned up front so every path drives every
        // output and no latch is inferred.
        w_mode_nxt = r_mode;
        w_led_nxt  = r_led;
        w_dir_nxt  = r_dir;

        if (w_press) begin
            w_mode_nxt = mode_t'(r_mode + 2'd1);
            w_led_nxt  = 4'b0000;
            w_dir_nxt  = 1'b0;
        end else if (w_step) begin
            case (r_mode)
                M_COUNT_UP: begin
                    w_led_nxt = r_led + 4'd1;
                end
                M_COUNT_DOWN: begin
                    w_led_nxt = r_led - 4'd1;
                end
                M_CHASE: begin
                    w_led_nxt = w_one_hot ? {r_led[2:0], r_led[3]} : 4'b0001;
                end
                M_BOUNCE: begin
                    if (!w_one_hot) begin
                        w_led_nxt = 4'b0001;
                        w_dir_nxt = 1'b0;
                    end else if (!r_dir) begin
                        if (r_led == 4'b1000) begin
                            w_led_nxt = 4'b0100;
                            w_dir_nxt = 1'b1;
                        end else begin
                            w_led_nxt = {r_led[2:0], 1'b0};
                        end
                    end else begin
                        if (r_led == 4'b0001) begin
                            w_led_nxt = 4'b0010;
                            w_dir_nxt = 1'b0;
                        end else begin
                            w_led_nxt = {1'b0, r_led[3:1]};
                        end
                    end
                end
                default: begin
                    w_led_nxt = r_led;
                end
            endcase
        end
    end

    assign io_bus.LED  = r_led;
    assign io_bus.MODE = r_mode;

endmodule

// File: tb/tb_led_pattern_seq.sv
// Self-checking bench for led_pattern_seq. Expected LED/MODE values are
// pushed to a scoreboard queue when the stimulus is driven and popped when
// the sequencer is due to show them. Works with LED_DEBOUNCE_EN defined
// (DEBOUNCE_CYCLES = 4) or undefined.
module tb_led_pattern_seq;

    localparam int DBC = 4;
`ifdef LED_DEBOUNCE_EN
    // KEY first sampled low at edge n -> press at edge n+1+DEBOUNCE_CYCLES.
    localparam int KEY_LAT        = DBC + 1;
    // Short bursts are filtered out entirely.
    localparam int BOUNCE_PRESSES = 0;
`else
    // Accepted level follows k2 directly -> press at edge n+2.
    localparam int KEY_LAT        = 2;
    // Each of the two short low bursts is a separate press.
    localparam int BOUNCE_PRESSES = 2;
`endif

    typedef struct {
        logic [3:0] led;
        logic [1:0] mode;
        string      name;
    } exp_t;

    logic CLK;
    logic RST;
    led_pattern_seq_if bus ();

    led_pattern_seq #(
        .DEBOUNCE_CYCLES (DBC),
        .DB_W            (8)
    ) dut (
        .CLK    (CLK),
        .RST    (RST),
        .io_bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    exp_t       sb[$];
    exp_t       e;
    int         n_vec = 0;
    int         n_err = 0;
    int         m_exp = 0;          // bench's view of the current mode
    logic [3:0] led_exp = 4'b0000;  // bench's view of the LEDs

    function automatic exp_t mk(input logic [3:0] led, input int mode, input string name);
        exp_t r;
        r.led  = led;
        r.mode = 2'(mode % 4);
        r.name = name;
        return r;
    endfunction

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Raise TIME; return the LEDs one edge after TIME is first sampled and
    // stop just after the edge where the step is due to land.
    task automatic step_to_update(output logic [3:0] led_early);
        bus.TIME = 1'b1;
        tick();             // edge n: TIME sampled high
        tick();             // edge n+1: step not applied yet
        led_early = bus.LED;
        tick();             // edge n+2: LED updated
    endtask

    // Complete the 5-high / 5-low TIME pulse.
    task automatic step_tail();
        repeat (2) tick();
        bus.TIME = 1'b0;
        repeat (5) tick();
    endtask

    // Clean press: long enough low, then released long enough to settle.
    task automatic key_press();
        bus.KEY = 1'b0;
        repeat (KEY_LAT + 2) tick();
        bus.KEY = 1'b1;
        repeat (KEY_LAT + 3) tick();
    endtask

    task automatic test_reset();
        RST      = 1'b1;
        bus.TIME = 1'b0;
        bus.KEY  = 1'b1;
        repeat (2) tick();
        sb.push_back(mk(4'b0000, 0, "reset"));
        e = sb.pop_front();
        n_vec++;
        if (bus.LED !== e.led || bus.MODE !== e.mode) begin
            n_err++;
            $display("FAIL %s: got LED=%b MODE=%0d, want LED=%b MODE=%0d",
                     e.name, bus.LED, bus.MODE, e.led, e.mode);
        end
        RST = 1'b0;
        repeat (3) tick();
        n_vec++;
        if (bus.LED !== 4'b0000 || bus.MODE !== 2'd0) begin
            n_err++;
            $display("FAIL reset_idle: got LED=%b MODE=%0d, want LED=0000 MODE=0",
                     bus.LED, bus.MODE);
        end
        m_exp   = 0;
        led_exp = 4'b0000;
    endtask

    task automatic test_count_up();
        logic [3:0] early;
        for (int i = 1; i <= 17; i++) begin
            sb.push_back(mk(4'(i % 16), 0, $sformatf("count_up[%0d]", i)));
            step_to_update(early);
            n_vec++;
            if (early !== led_exp) begin
                n_err++;
                $display("FAIL count_up_early[%0d]: got LED=%b, want LED=%b",
                         i, early, led_exp);
            end
            e = sb.pop_front();
            n_vec++;
            if (bus.LED !== e.led || bus.MODE !== e.mode) begin
                n_err++;
                $display("FAIL %s: got LED=%b MODE=%0d, want LED=%b MODE=%0d",
                         e.name, bus.LED, bus.MODE, e.led, e.mode);
            end
            led_exp = e.led;
            step_tail();
        end
    endtask

    task automatic test_clean_press();
        logic [3:0] down_tbl [2];
        logic [3:0] early;
        down_tbl = '{4'b1111, 4'b1110};
        sb.push_back(mk(4'b0000, m_exp + 1, "press_edge"));
        bus.KEY = 1'b0;
        repeat (KEY_LAT) tick();    // one edge before the press edge
        n_vec++;
        if (bus.MODE !== 2'(m_exp) || bus.LED !== led_exp) begin
            n_err++;
            $display("FAIL press_early: got LED=%b MODE=%0d, want LED=%b MODE=%0d",
                     bus.LED, bus.MODE, led_exp, m_exp);
        end
        tick();                     // press edge
        e = sb.pop_front();
        n_vec++;
        if (bus.LED !== e.led || bus.MODE !== e.mode) begin
            n_err++;
            $display("FAIL %s: got LED=%b MODE=%0d, want LED=%b MODE=%0d",
                     e.name, bus.LED, bus.MODE, e.led, e.mode);
        end
        repeat (10 - KEY_LAT - 1) tick();   // KEY low for 10 cycles in total
        bus.KEY = 1'b1;
        repeat (KEY_LAT + 3) tick();
        m_exp   = (m_exp + 1) % 4;
        led_exp = 4'b0000;
        n_vec++;
        if (bus.MODE !== 2'(m_exp) || bus.LED !== 4'b0000) begin
            n_err++;
            $display("FAIL release_no_effect: got LED=%b MODE=%0d, want LED=0000 MODE=%0d",
                     bus.LED, bus.MODE, m_exp);
        end
        for (int i = 0; i < 2; i++) begin
            sb.push_back(mk(down_tbl[i], m_exp, $sformatf("count_down[%0d]", i)));
            step_to_update(early);
            e = sb.pop_front();
            n_vec++;
            if (bus.LED !== e.led || bus.MODE !== e.mode) begin
                n_err++;
                $display("FAIL %s: got LED=%b MODE=%0d, want LED=%b MODE=%0d",
                         e.name, bus.LED, bus.MODE, e.led, e.mode);
            end
            led_exp = e.led;
            step_tail();
        end
    endtask

    task automatic test_bounce_reject();
        bus.KEY = 1'b0; repeat (3) tick();
        bus.KEY = 1'b1; tick();
        bus.KEY = 1'b0; repeat (3) tick();
        bus.KEY = 1'b1; repeat (KEY_LAT + 3) tick();
        m_exp = (m_exp + BOUNCE_PRESSES) % 4;
        if (BOUNCE_PRESSES != 0) led_exp = 4'b0000;
        sb.push_back(mk(led_exp, m_exp, "bounce_bursts"));
        e = sb.pop_front();
        n_vec++;
        if (bus.LED !== e.led || bus.MODE !== e.mode) begin
            n_err++;
            $display("FAIL %s: got LED=%b MODE=%0d, want LED=%b MODE=%0d",
                     e.name, bus.LED, bus.MODE, e.led, e.mode);
        end
        bus.KEY = 1'b0; repeat (6) tick();
        bus.KEY = 1'b1; repeat (KEY_LAT + 3) tick();
        m_exp   = (m_exp + 1) % 4;
        led_exp = 4'b0000;
        sb.push_back(mk(led_exp, m_exp, "bounce_then_hold"));
        e = sb.pop_front();
        n_vec++;
        if (bus.LED !== e.led || bus.MODE !== e.mode) begin
            n_err++;
            $display("FAIL %s: got LED=%b MODE=%0d, want LED=%b MODE=%0d",
                     e.name, bus.LED, bus.MODE, e.led, e.mode);
        end
    endtask

    task automatic test_chase_bounce();
        logic [3:0] chase_tbl  [5];
        logic [3:0] bounce_tbl [8];
        logic [3:0] early;
        chase_tbl  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        bounce_tbl = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                       4'b0100, 4'b0010, 4'b0001, 4'b0010};
        while (m_exp != 2) begin
            sb.push_back(mk(4'b0000, m_exp + 1, $sformatf("press_to_%0d", (m_exp + 1) % 4)));
            key_press();
            e = sb.pop_front();
            n_vec++;
            if (bus.LED !== e.led || bus.MODE !== e.mode) begin
                n_err++;
                $display("FAIL %s: got LED=%b MODE=%0d, want LED=%b MODE=%0d",
                         e.name, bus.LED, bus.MODE, e.led, e.mode);
            end
            m_exp = (m_exp + 1) % 4;
        end
        for (int i = 0; i < 5; i++) begin
            sb.push_back(mk(chase_tbl[i], 2, $sformatf("chase[%0d]", i)));
            step_to_update(early);
            e = sb.pop_front();
            n_vec++;
            if (bus.LED !== e.led || bus.MODE !== e.mode) begin
                n_err++;
                $display("FAIL %s: got LED=%b MODE=%0d, want LED=%b MODE=%0d",
                         e.name, bus.LED, bus.MODE, e.led, e.mode);
            end
            step_tail();
        end
        sb.push_back(mk(4'b0000, 3, "press_to_bounce"));
        key_press();
        e = sb.pop_front();
        n_vec++;
        if (bus.LED !== e.led || bus.MODE !== e.mode) begin
            n_err++;
            $display("FAIL %s: got LED=%b MODE=%0d, want LED=%b MODE=%0d",
                     e.name, bus.LED, bus.MODE, e.led, e.mode);
        end
        m_exp = 3;
        for (int i = 0; i < 8; i++) begin
            sb.push_back(mk(bounce_tbl[i], 3, $sformatf("bounce[%0d]", i)));
            step_to_update(early);
            e = sb.pop_front();
            n_vec++;
            if (bus.LED !== e.led || bus.MODE !== e.mode) begin
                n_err++;
                $display("FAIL %s: got LED=%b MODE=%0d, want LED=%b MODE=%0d",
                         e.name, bus.LED, bus.MODE, e.led, e.mode);
            end
            step_tail();
        end
        led_exp = 4'b0010;
    endtask

    task automatic test_mode_wrap();
        sb.push_back(mk(4'b0000, 0, "mode_wrap_3_to_0"));
        key_press();
        e = sb.pop_front();
        n_vec++;
        if (bus.LED !== e.led || bus.MODE !== e.mode) begin
            n_err++;
            $display("FAIL %s: got LED=%b MODE=%0d, want LED=%b MODE=%0d",
                     e.name, bus.LED, bus.MODE, e.led, e.mode);
        end
        m_exp   = 0;
        led_exp = 4'b0000;
    endtask

    task automatic test_simultaneous();
        logic [3:0] early;
        for (int i = 1; i <= 5; i++) begin
            sb.push_back(mk(4'(i), 0, $sformatf("pre_sim_up[%0d]", i)));
            step_to_update(early);
            e = sb.pop_front();
            n_vec++;
            if (bus.LED !== e.led || bus.MODE !== e.mode) begin
                n_err++;
                $display("FAIL %s: got LED=%b MODE=%0d, want LED=%b MODE=%0d",
                         e.name, bus.LED, bus.MODE, e.led, e.mode);
            end
            step_tail();
        end
        // Step due on the same edge as the press: press wins, step is lost.
        sb.push_back(mk(4'b0000, 1, "press_beats_step"));
        bus.KEY = 1'b0;
        repeat (KEY_LAT - 2) tick();
        bus.TIME = 1'b1;
        repeat (3) tick();
        e = sb.pop_front();
        n_vec++;
        if (bus.LED !== e.led || bus.MODE !== e.mode) begin
            n_err++;
            $display("FAIL %s: got LED=%b MODE=%0d, want LED=%b MODE=%0d",
                     e.name, bus.LED, bus.MODE, e.led, e.mode);
        end
        repeat (4) tick();
        bus.KEY  = 1'b1;
        bus.TIME = 1'b0;
        repeat (KEY_LAT + 3) tick();
        n_vec++;
        if (bus.LED !== 4'b0000 || bus.MODE !== 2'd1) begin
            n_err++;
            $display("FAIL step_not_deferred: got LED=%b MODE=%0d, want LED=0000 MODE=1",
                     bus.LED, bus.MODE);
        end
        m_exp   = 1;
        led_exp = 4'b0000;
    endtask

    task automatic test_reset_mid();
        logic [3:0] pre_tbl [5];
        logic [3:0] early;
        pre_tbl = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100};
        for (int p = 0; p < 2; p++) begin
            sb.push_back(mk(4'b0000, m_exp + 1, $sformatf("press_mid[%0d]", p)));
            key_press();
            e = sb.pop_front();
            n_vec++;
            if (bus.LED !== e.led || bus.MODE !== e.mode) begin
                n_err++;
                $display("FAIL %s: got LED=%b MODE=%0d, want LED=%b MODE=%0d",
                         e.name, bus.LED, bus.MODE, e.led, e.mode);
            end
            m_exp = (m_exp + 1) % 4;
        end
        // Bounce mode to LED 0100 moving right (dir = 1).
        for (int i = 0; i < 5; i++) begin
            sb.push_back(mk(pre_tbl[i], 3, $sformatf("pre_reset_bounce[%0d]", i)));
            step_to_update(early);
            e = sb.pop_front();
            n_vec++;
            if (bus.LED !== e.led || bus.MODE !== e.mode) begin
                n_err++;
                $display("FAIL %s: got LED=%b MODE=%0d, want LED=%b MODE=%0d",
                         e.name, bus.LED, bus.MODE, e.led, e.mode);
            end
            step_tail();
        end
        // Debounce count reaches 2 and TIME goes high, then one reset edge.
        bus.KEY = 1'b0;
        repeat (3) tick();
        bus.TIME = 1'b1;
        tick();
        RST = 1'b1;
        sb.push_back(mk(4'b0000, 0, "reset_mid"));
        tick();
        e = sb.pop_front();
        n_vec++;
        if (bus.LED !== e.led || bus.MODE !== e.mode) begin
            n_err++;
            $display("FAIL %s: got LED=%b MODE=%0d, want LED=%b MODE=%0d",
                     e.name, bus.LED, bus.MODE, e.led, e.mode);
        end
        RST     = 1'b0;
        bus.KEY = 1'b1;
        // TIME held high: sampled at the first edge after release, step lands
        // two edges later.
        sb.push_back(mk(4'b0001, 0, "post_reset_step"));
        repeat (2) tick();
        n_vec++;
        if (bus.LED !== 4'b0000) begin
            n_err++;
            $display("FAIL post_reset_early: got LED=%b, want LED=0000", bus.LED);
        end
        tick();
        e = sb.pop_front();
        n_vec++;
        if (bus.LED !== e.led || bus.MODE !== e.mode) begin
            n_err++;
            $display("FAIL %s: got LED=%b MODE=%0d, want LED=%b MODE=%0d",
                     e.name, bus.LED, bus.MODE, e.led, e.mode);
        end
        repeat (12) tick();
        n_vec++;
        if (bus.LED !== 4'b0001 || bus.MODE !== 2'd0) begin
            n_err++;
            $display("FAIL post_reset_single_step: got LED=%b MODE=%0d, want LED=0001 MODE=0",
                     bus.LED, bus.MODE);
        end
        bus.TIME = 1'b0;
        repeat (3) tick();
    endtask

    initial begin
        RST      = 1'b1;
        bus.TIME = 1'b0;
        bus.KEY  = 1'b1;
        test_reset();
        test_count_up();
        test_clean_press();
        test_bounce_reject();
        test_chase_bounce();
        test_mode_wrap();
        test_simultaneous();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
